// File: rtl/frequency_generator.sv
// Square-wave source: a commanded frequency in Hz is turned into a half-period
// cycle count by a sequential restoring divider, then a toggle counter emits the wave.
module frequency_generator #(
  parameter int CLK_HZ = 100000000,
  parameter int FREQ_W = 18,
  parameter int DIV_W  = 27
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  output logic              load_ready,
  input  logic [FREQ_W-1:0] freq_hz,
  output logic              pulse_out,
  output logic [DIV_W-1:0]  half_period,
  output logic              period_valid,
  output logic              busy,
  output logic [FREQ_W-1:0] edge_count
);

  localparam int CMP_W = (DIV_W + 2 > FREQ_W + 1) ? DIV_W + 2 : FREQ_W + 1;
  localparam int BIT_W = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    RUN
  } state_t;

  state_t             state;
  logic [FREQ_W-1:0]  freq_reg;
  logic [DIV_W-1:0]   dividend_sr;
  logic [DIV_W-1:0]   quotient;
  logic [DIV_W:0]     remainder;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   counter;

  logic [FREQ_W:0]    divisor;
  logic [DIV_W+1:0]   rem_shift;
  logic               q_bit;
  logic [DIV_W:0]     rem_next;
  logic [DIV_W-1:0]   quot_next;
  logic [DIV_W-1:0]   final_hp;
  logic               terminal;

  assign load_ready = (state != DIVIDE);

  // One restoring-division step: bring down the next dividend bit and subtract
  // the divisor whenever it fits. A zero frequency bypasses the clamp to 1.
  always_comb begin
    divisor   = {freq_reg, 1'b0};
    rem_shift = {remainder, dividend_sr[DIV_W-1]};
    q_bit     = (CMP_W'(rem_shift) >= CMP_W'(divisor));
    rem_next  = q_bit ? (DIV_W+1)'(rem_shift - (DIV_W+2)'(divisor))
                      : (DIV_W+1)'(rem_shift);
    quot_next = DIV_W'({quotient, q_bit});
    if (freq_reg == '0) begin
      final_hp = '0;
    end else if (quot_next == '0) begin
      final_hp = DIV_W'(1);
    end else begin
      final_hp = quot_next;
    end
    terminal = (counter == half_period - DIV_W'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      pulse_out    <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      busy         <= 1'b0;
      edge_count   <= '0;
      counter      <= '0;
      freq_reg     <= '0;
      dividend_sr  <= '0;
      remainder    <= '0;
      quotient     <= '0;
      bit_cnt      <= '0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        DIVIDE: begin
          dividend_sr <= dividend_sr << 1;
          remainder   <= rem_next;
          quotient    <= quot_next;
          bit_cnt     <= bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            half_period  <= final_hp;
            period_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= RUN;
          end
        end
        default: begin
          // A load abandons the current waveform at once; no partial period leaks out.
          if (load) begin
            freq_reg    <= freq_hz;
            dividend_sr <= DIVIDEND;
            remainder   <= '0;
            quotient    <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            pulse_out   <= 1'b0;
            counter     <= '0;
            edge_count  <= '0;
            state       <= DIVIDE;
          end else if (state == RUN && enable && half_period != '0) begin
            if (terminal) begin
              counter   <= '0;
              pulse_out <= ~pulse_out;
              if (!pulse_out) begin
                edge_count <= edge_count + FREQ_W'(1);
              end
            end else begin
              counter <= counter + DIV_W'(1);
            end
          end
        end
      endcase
      // Disabling silences the output in every state but lets a divide finish.
      if (!enable) begin
        pulse_out <= 1'b0;
        counter   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: table of frequencies, hand-written corner cases,
// and randomized traffic compared every cycle against an arithmetic reference model.
module tb_frequency_generator;

  localparam int CLK_HZ = 1000;
  localparam int FREQ_W = 18;
  localparam int DIV_W  = 10;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              load;
  logic              load_ready;
  logic [FREQ_W-1:0] freq_hz;
  logic              pulse_out;
  logic [DIV_W-1:0]  half_period;
  logic              period_valid;
  logic              busy;
  logic [FREQ_W-1:0] edge_count;

  logic              big_load;
  logic              big_load_ready;
  logic [17:0]       big_freq;
  logic              big_pulse;
  logic [26:0]       big_half_period;
  logic              big_valid;
  logic              big_busy;
  logic [17:0]       big_edge_count;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int freq;
    int exp_hp;
  } vec_t;

  // Reference model state: phase counts active RUN cycles since the waveform restarted.
  int m_mode;
  int m_div_left;
  int m_freq;
  int m_hp;
  int m_t;
  int m_base;
  bit m_valid;
  bit m_busy;

  always #5 clock = ~clock;

  frequency_generator #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W), .DIV_W(DIV_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_ready(load_ready), .freq_hz(freq_hz), .pulse_out(pulse_out),
    .half_period(half_period), .period_valid(period_valid), .busy(busy),
    .edge_count(edge_count)
  );

  frequency_generator dut_big (
    .clock(clock), .reset(reset), .enable(enable), .load(big_load),
    .load_ready(big_load_ready), .freq_hz(big_freq), .pulse_out(big_pulse),
    .half_period(big_half_period), .period_valid(big_valid), .busy(big_busy),
    .edge_count(big_edge_count)
  );

  function automatic int ref_hp(int f);
    int q;
    if (f == 0) return 0;
    q = CLK_HZ / (2 * f);
    return (q == 0) ? 1 : q;
  endfunction

  function automatic int rises(int t, int hp);
    if (hp == 0) return 0;
    return ((t / hp) + 1) / 2;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_div_left = 0; m_freq = 0; m_hp = 0;
      m_t = 0; m_base = 0; m_valid = 1'b0; m_busy = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if (m_mode != 1 && load) begin
      m_freq = int'(freq_hz);
      m_mode = 1;
      m_div_left = DIV_W;
      m_t = 0;
      m_base = 0;
      m_busy = 1'b1;
    end else if (m_mode == 1) begin
      m_div_left--;
      if (m_div_left == 0) begin
        m_hp = ref_hp(m_freq);
        m_valid = 1'b1;
        m_busy = 1'b0;
        m_mode = 2;
        m_t = 0;
      end
    end else if (m_mode == 2 && enable && m_hp != 0) begin
      m_t++;
    end
    if (!enable) begin
      m_base += rises(m_t, m_hp);
      m_t = 0;
    end
  endtask

  task automatic compare_model();
    int exp_pulse;
    exp_pulse = (m_mode == 2 && m_hp != 0) ? ((m_t / m_hp) % 2) : 0;
    check_output("model_pulse_out", pulse_out, exp_pulse);
    check_output("model_edge_count", edge_count, (m_base + rises(m_t, m_hp)) % (1 << FREQ_W));
    check_output("model_half_period", half_period, m_hp);
    check_output("model_period_valid", period_valid, m_valid);
    check_output("model_busy", busy, m_busy);
    check_output("model_load_ready", load_ready, (m_mode != 1));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic apply_stimulus(input int f);
    load = 1'b1;
    freq_hz = FREQ_W'(f);
    tick();
    load = 1'b0;
  endtask

  // Latency is counted in cycles from the load cycle to the period_valid cycle.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (period_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_pulse(input logic level, output int n);
    n = 0;
    while (pulse_out !== level && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int lat;
    int n;
    int valid_seen;

    vecs = '{'{50, 10}, '{3, 166}, '{600, 1}, '{0, 0}, '{1, 500},
             '{500, 1}, '{499, 1}, '{250, 2}, '{333, 1}, '{7, 71}};

    reset = 1'b1; enable = 1'b1; load = 1'b0; freq_hz = '0;
    big_load = 1'b0; big_freq = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_output("reset_load_ready", load_ready, 1);
    check_output("reset_pulse_out", pulse_out, 0);
    check_output("reset_half_period", half_period, 0);
    check_output("reset_edge_count", edge_count, 0);

    // Reset in the middle of a divide must abandon it completely.
    apply_stimulus(50);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("middiv_busy", busy, 0);
    check_output("middiv_load_ready", load_ready, 1);
    check_output("middiv_half_period", half_period, 0);
    valid_seen = 0;
    repeat (15) begin
      tick();
      if (period_valid === 1'b1) valid_seen++;
    end
    check_output("middiv_no_valid", valid_seen, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].freq);
      wait_valid(lat);
      check_output($sformatf("table_latency_f%0d", vecs[i].freq), lat, DIV_W + 1);
      check_output($sformatf("table_hp_f%0d", vecs[i].freq), half_period, vecs[i].exp_hp);
      repeat ((vecs[i].exp_hp * 4 + 5 > 200) ? 200 : vecs[i].exp_hp * 4 + 5) tick();
    end

    // 50 Hz: first rise half a period after RUN entry, then five clean periods.
    apply_stimulus(50);
    wait_valid(lat);
    check_output("f50_latency", lat, 11);
    check_output("f50_hp", half_period, 10);
    wait_pulse(1'b1, n);
    check_output("f50_first_rise", n, 10);
    repeat (80) tick();
    check_output("f50_edges_after_5", edge_count, 5);
    check_output("f50_pulse_high", pulse_out, 1);

    // Reload while the output is high: output and edge count clear immediately.
    apply_stimulus(3);
    check_output("reload_pulse_low", pulse_out, 0);
    check_output("reload_edge_clear", edge_count, 0);
    wait_valid(lat);
    check_output("reload_latency", lat, 11);
    check_output("reload_hp", half_period, 166);

    // A load during DIVIDE is dropped, not queued.
    apply_stimulus(50);
    check_output("divide_load_ready", load_ready, 0);
    apply_stimulus(3);
    wait_valid(lat);
    check_output("ignored_load_latency", lat, DIV_W);
    check_output("ignored_load_hp", half_period, 10);

    // Enable gap while high: output drops, edge count holds, restart from zero.
    wait_pulse(1'b1, n);
    check_output("gap_first_rise", n, 10);
    enable = 1'b0;
    tick();
    check_output("gap_pulse_low", pulse_out, 0);
    check_output("gap_edge_hold", edge_count, 1);
    repeat (6) tick();
    enable = 1'b1;
    wait_pulse(1'b1, n);
    check_output("gap_rerise", n, 10);
    check_output("gap_edge_after", edge_count, 2);

    // Clamped half period of 1 toggles every cycle.
    apply_stimulus(600);
    wait_valid(lat);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output($sformatf("f600_toggle_%0d", i), pulse_out, (i % 2 == 0));
    end
    check_output("f600_edges", edge_count, 3);

    // Zero frequency keeps the output parked low.
    apply_stimulus(0);
    wait_valid(lat);
    repeat (50) tick();
    check_output("f0_pulse", pulse_out, 0);
    check_output("f0_edges", edge_count, 0);
    check_output("f0_hp", half_period, 0);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      enable  = ($urandom_range(0, 15) != 0);
      load    = ($urandom_range(0, 19) == 0);
      freq_hz = FREQ_W'($urandom_range(0, 700));
      tick();
    end
    reset = 1'b0; enable = 1'b1; load = 1'b0;
    tick();

    // Full-size instance with default parameters.
    big_freq = 18'd20;
    big_load = 1'b1;
    tick();
    big_load = 1'b0;
    lat = 1;
    while (big_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check_output("big_latency", lat, 28);
    check_output("big_hp", big_half_period, 2500000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
- Square-wave source driven by a commanded frequency in Hz; the transmit-side counterpart of the frequency counter.
- Emulates a colour-sensor output for closed-loop self-test of the measurement path, and doubles as a general tone/pulse source for rover peripherals.
- A commanded frequency is converted to a half-period cycle count by an on-chip sequential restoring divider, then a toggle counter produces the waveform.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz (dividend).
- FREQ_W, 18, width of commanded frequency and edge counter.
- DIV_W, 27, divider/half-period width; must satisfy 2^DIV_W > CLK_HZ.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run gate; low forces output low and holds the toggle counter cleared.
- load  in  1  request to accept freq_hz; qualified by load_ready.
- load_ready  out  1  high when a load is accepted this cycle.
- freq_hz  in  FREQ_W  commanded frequency in Hz, sampled on accepted load.
- pulse_out  out  1  generated square wave.
- half_period  out  DIV_W  current half-period in clock cycles, after clamping.
- period_valid  out  1  one-cycle strobe when the divide completes.
- busy  out  1  high while dividing.
- edge_count  out  FREQ_W  rising edges emitted on pulse_out since last accepted load; wraps.

Behaviour:
- Reset values (synchronous, active-high):
  - state=IDLE, pulse_out=0, half_period=0, period_valid=0, busy=0, edge_count=0.
  - Internal toggle counter=0, divider registers=0.
  - Reset overrides everything, including mid-divide.
- States:
  - IDLE: load_ready=1, pulse_out=0. An accepted load latches freq_hz, goes to DIVIDE, sets busy=1.
  - DIVIDE: restoring division of CLK_HZ by divisor 2*freq_hz (FREQ_W+1 bits).
    - One quotient bit per cycle, MSB first, exactly DIV_W cycles.
    - load_ready=0; load is ignored, not queued.
    - pulse_out=0, counter=0.
  - Divide completion, on the cycle after the last quotient bit:
    - half_period <= quotient; a quotient of 0 with freq_hz≠0 is clamped to 1.
    - freq_hz=0 bypasses the clamp and gives half_period=0.
    - period_valid=1 for exactly one cycle, busy=0, state=RUN.
    - Total latency: accepted load at cycle N → period_valid at cycle N+DIV_W+1.
  - RUN: load_ready=1.
    - When enable=1 and half_period≠0, the counter increments each cycle.
    - When counter reaches half_period-1: counter <= 0 and pulse_out toggles.
    - Each 0→1 toggle increments edge_count, wrapping at 2^FREQ_W.
    - First toggle (to 1) occurs half_period cycles after entry into RUN.
    - Waveform period = 2*half_period cycles, 50% duty.
    - half_period=0: pulse_out stays 0 permanently, counter idle.
- Reload in RUN: an accepted load immediately forces pulse_out=0, counter=0, edge_count=0, then enters DIVIDE. No partial period is emitted.
- Simultaneous load and terminal count in RUN: load wins, no toggle, edge_count not incremented.
- enable=0, any state:
  - pulse_out=0 and counter=0 the next cycle.
  - The divide continues; state, half_period and edge_count are retained.
  - When enable returns to 1 in RUN, counting restarts from 0 with pulse_out low.
  - Falling to 0 from a high output does not count an edge.
- Arithmetic:
  - Divisor computed as {freq_hz,1'b0}, so there is no overflow.
  - Remainder register is DIV_W+1 bits; quotient truncates (floor).

Test Plan (CLK_HZ=1000, DIV_W=10, FREQ_W=18 unless stated):
- Reset mid-DIVIDE (load 50, assert reset 4 cycles later) → next cycle all outputs 0, state IDLE, load_ready=1, no period_valid ever.
- freq_hz=50 load at cycle 0 → period_valid at cycle 11 with half_period=10; pulse_out rises 10 cycles later, then period 20 cycles. After 5 full periods, edge_count=5.
- freq_hz=3 → half_period=166; freq_hz=600 → quotient 0 clamped to 1, pulse_out toggles every cycle; freq_hz=0 → half_period=0, pulse_out held 0, edge_count stays 0.
- Load 50, then load 3 during DIVIDE → second load ignored (load_ready=0), half_period=10. Load 3 in RUN while pulse_out=1 → pulse_out=0 and edge_count=0 next cycle, period_valid after 11 cycles, half_period=166.
- enable dropped for 7 cycles while pulse_out=1 with half_period=10 → pulse_out 0 next cycle, edge_count unchanged. Re-enable → first rise exactly 10 cycles later.
- Default params, freq_hz=20 → half_period=2500000; a loopback into the frequency counter with CS_state=1 reports frequency=20 on each flag_done.
